// File: rtl/uart_link_pkg.sv
// Shared types and default constants for the UART transmit link.
// Used by the TX arbiter and its round-robin picker.
package uart_link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } state_e;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 10;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first requester at or above ptr_i, wrapping.
// Purely combinational.
module uart_rr_pick
    import uart_link_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    int c;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        c       = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr_i) + k;
            if (c >= N) c = c - N;
            if (!found_o && req_i[W'(c)]) begin
                found_o = 1'b1;
                idx_o   = W'(c);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a credit-tracked TX FIFO, with
// message-level grants, stall timeout and overflow detection.
module uart_tx_arbiter
    import uart_link_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            ena,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [DATA_WIDTH-1:0]           fifo_data,
    output logic                            fifo_push,
    input  logic                            fifo_pop,
    output logic [$clog2(NUM_REQ)-1:0]      grant,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] credits,
    output logic                            err_overflow,
    output logic                            timeout_evt
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

    state_e                  state_q;
    logic [GW-1:0]           ptr_q;
    logic [GW-1:0]           grant_q;
    logic [CW-1:0]           credits_q;
    logic [IW-1:0]           idle_q;
    logic                    push_q;
    logic                    ovf_q;
    logic                    tmo_q;
    logic [DATA_WIDTH-1:0]   data_q;

    logic [GW-1:0]           pick_idx;
    logic                    pick_found;
    logic                    can_send;
    logic                    accept;
    logic                    pop_en;
    logic                    cur_last;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic [GW-1:0]           ptr_next;

    uart_rr_pick #(
        .N (NUM_REQ),
        .W (GW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign can_send = ena && (state_q == XFER) && (credits_q != '0);

    always_comb begin
        req_ready          = '0;
        req_ready[grant_q] = can_send;
    end

    assign accept   = can_send && req_valid[grant_q];
    assign cur_data = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign cur_last = req_last[grant_q];
    assign pop_en   = ena && fifo_pop;
    assign ptr_next = (grant_q == LAST_IDX) ? '0 : grant_q + GW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            credits_q <= FULL;
            idle_q    <= '0;
            push_q    <= 1'b0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            data_q    <= '0;
        end else if (ena) begin
            push_q <= accept;
            tmo_q  <= 1'b0;
            if (accept) data_q <= cur_data;
            // A pop with nothing outstanding is a FIFO protocol error
            if (pop_en && credits_q == FULL) ovf_q <= 1'b1;
            if (accept && !pop_en)
                credits_q <= credits_q - CW'(1);
            else if (pop_en && !accept && credits_q != FULL)
                credits_q <= credits_q + CW'(1);
            unique case (state_q)
                IDLE: if (|req_valid) state_q <= ARB;
                ARB: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        idle_q  <= '0;
                        state_q <= XFER;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                XFER: begin
                    if (accept) begin
                        idle_q <= '0;
                        if (cur_last) begin
                            state_q <= IDLE;
                            ptr_q   <= ptr_next;
                        end
                    end else if (idle_q == IDLE_MAX) begin
                        tmo_q   <= 1'b1;
                        idle_q  <= '0;
                        state_q <= IDLE;
                        ptr_q   <= ptr_next;
                    end else begin
                        idle_q <= idle_q + IW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end else begin
            tmo_q <= 1'b0;
        end
    end

    // A push registered just before ena dropped is held until ena returns
    assign fifo_push    = push_q & ena;
    assign fifo_data    = data_q;
    assign grant        = grant_q;
    assign busy         = (state_q != IDLE);
    assign credits      = credits_q;
    assign err_overflow = ovf_q;
    assign timeout_evt  = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with hand-computed expectations.
// Pushes and timeout pulses are captured on the falling edge.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ena = 1'b1;
    logic [31:0] req_data = '0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [7:0]  fifo_data;
    logic        fifo_push;
    logic        fifo_pop = 1'b0;
    logic [1:0]  grant;
    logic        busy;
    logic [3:0]  credits;
    logic        err_overflow;
    logic        timeout_evt;

    int checks = 0;
    int failures = 0;
    logic [7:0] pushq[$];
    int tmo_cnt = 0;
    int pb;
    int tb0;
    int order[$];
    logic [3:0] acc_v;
    bit ok;

    uart_tx_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ena          (ena),
        .req_data     (req_data),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_data    (fifo_data),
        .fifo_push    (fifo_push),
        .fifo_pop     (fifo_pop),
        .grant        (grant),
        .busy         (busy),
        .credits      (credits),
        .err_overflow (err_overflow),
        .timeout_evt  (timeout_evt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fifo_push) pushq.push_back(fifo_data);
        if (timeout_evt) tmo_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        ena       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        fifo_pop  = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        pb  = pushq.size();
        tb0 = tmo_cnt;
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic l,
                        output bit acc);
        acc = 1'b0;
        req_data[i*8 +: 8] = d;
        req_last[i]  = l;
        req_valid[i] = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (req_ready[i]) begin
                acc = 1'b1;
                tick();
                break;
            end
            tick();
        end
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_credits", credits, 10);
        chk("rst_push", fifo_push, 0);
        chk("rst_ovf", err_overflow, 0);
        chk("rst_tmo", timeout_evt, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_grant", grant, 0);
        do_reset();

        // single message on req0
        send(0, 8'h41, 1'b0, ok);
        chk("s1_send0", ok, 1);
        chk("s1_lat_push", fifo_push, 1);
        chk("s1_lat_data", fifo_data, 8'h41);
        chk("s1_grant", grant, 0);
        send(0, 8'h42, 1'b0, ok);
        chk("s1_send1", ok, 1);
        send(0, 8'h43, 1'b1, ok);
        chk("s1_send2", ok, 1);
        chk("s1_busy", busy, 0);
        chk("s1_credits", credits, 7);
        chk("s1_ptr", dut.ptr_q, 1);
        repeat (2) tick();
        chk("s1_npush", pushq.size() - pb, 3);
        chk("s1_b0", pushq[pb], 8'h41);
        chk("s1_b1", pushq[pb+1], 8'h42);
        chk("s1_b2", pushq[pb+2], 8'h43);

        // round robin req1 and req3
        do_reset();
        req_data[15:8]  = 8'h11;
        req_data[31:24] = 8'h33;
        req_last  = 4'b1010;
        req_valid = 4'b1010;
        order.delete();
        for (int n = 0; n < 30 && order.size() < 2; n++) begin
            acc_v = req_valid & req_ready;
            tick();
            for (int i = 0; i < 4; i++) begin
                if (acc_v[i]) begin
                    order.push_back(i);
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
        chk("s2_count", order.size(), 2);
        chk("s2_first", order[0], 1);
        chk("s2_second", order[1], 3);
        chk("s2_ptr", dut.ptr_q, 0);
        repeat (2) tick();
        chk("s2_b0", pushq[pb], 8'h11);
        chk("s2_b1", pushq[pb+1], 8'h33);

        // credit stall
        do_reset();
        for (int k = 0; k < 10; k++) begin
            send(0, 8'(8'h60 + k), 1'b0, ok);
            chk("s3_send", ok, 1);
        end
        chk("s3_credits0", credits, 0);
        req_data[7:0] = 8'h6A;
        req_last[0]   = 1'b1;
        req_valid[0]  = 1'b1;
        chk("s3_ready_lo", req_ready, 0);
        repeat (3) tick();
        chk("s3_ready_hold", req_ready, 0);
        fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        chk("s3_credits1", credits, 1);
        chk("s3_ready_hi", req_ready, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        chk("s3_credits_end", credits, 0);
        chk("s3_push", fifo_push, 1);
        chk("s3_data", fifo_data, 8'h6A);
        chk("s3_busy", busy, 0);

        // timeout on req2
        do_reset();
        req_valid[2] = 1'b1;
        for (int n = 0; n < 10 && !req_ready[2]; n++) tick();
        req_valid[2] = 1'b0;
        chk("s4_grant", grant, 2);
        repeat (254) tick();
        chk("s4_busy_pre", busy, 1);
        chk("s4_tmo_pre", timeout_evt, 0);
        tick();
        chk("s4_tmo", timeout_evt, 1);
        chk("s4_busy", busy, 0);
        chk("s4_ptr", dut.ptr_q, 3);
        repeat (5) tick();
        chk("s4_tmo_once", tmo_cnt - tb0, 1);

        // simultaneous push/pop, ena freeze, overflow
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(0, 8'(8'h50 + k), 1'b0, ok);
            chk("s5_send", ok, 1);
        end
        chk("s5_credits5", credits, 5);
        req_data[7:0] = 8'h55;
        req_valid[0]  = 1'b1;
        fifo_pop      = 1'b1;
        tick();
        chk("s5_credits_pp", credits, 5);
        chk("s5_ovf0", err_overflow, 0);
        req_valid[0] = 1'b0;
        ena          = 1'b0;
        #1;
        chk("s5_push_masked", fifo_push, 0);
        chk("s5_ready_masked", req_ready, 0);
        tick();
        chk("s5_credits_frz", credits, 5);
        chk("s5_busy_frz", busy, 1);
        ena      = 1'b1;
        fifo_pop = 1'b0;
        #1;
        chk("s5_push_held", fifo_push, 1);
        chk("s5_data_held", fifo_data, 8'h55);
        tick();
        chk("s5_push_clr", fifo_push, 0);
        do_reset();
        chk("s5_ovf_rst", err_overflow, 0);
        fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        chk("s5_ovf", err_overflow, 1);
        chk("s5_credits_full", credits, 10);

        // reset mid-XFER
        do_reset();
        send(0, 8'hA0, 1'b0, ok);
        chk("s6_send0", ok, 1);
        send(0, 8'hA1, 1'b0, ok);
        chk("s6_send1", ok, 1);
        chk("s6_inflight", fifo_push, 1);
        reset_n = 1'b0;
        #1;
        chk("s6_async_push", fifo_push, 0);
        chk("s6_async_busy", busy, 0);
        chk("s6_async_credits", credits, 10);
        tick();
        reset_n = 1'b1;
        tick();
        chk("s6_push", fifo_push, 0);
        chk("s6_credits", credits, 10);
        chk("s6_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
